eff_echo: RTL and testbench
===========================

EFF_ECHO -- requirements
Module: eff_echo

Interface
REQ-001 SHALL have parameter DATA_W, default 24, meaning the signed two's-complement sample width.
REQ-002 SHALL have parameter DEPTH, default 4096, meaning delay-buffer length in samples; must be a power of two, 16 or more.
REQ-003 SHALL have derived parameter ADDR_W = log2(DEPTH).
REQ-004 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-005 SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: 1 = echo applied, 0 = bypass.
REQ-007 SHALL have port delay, input, ADDR_W bits: echo distance in samples; 0 means DEPTH.
REQ-008 SHALL have port gain, input, 3 bits: feedback attenuation as an arithmetic right shift; 0 mutes the echo.
REQ-009 SHALL have port data_i, input, DATA_W bits, signed: input sample.
REQ-010 SHALL have port vld_i, input, 1 bit: single-cycle pulse qualifying data_i.
REQ-011 SHALL have port data_o, output, DATA_W bits, signed: processed sample.
REQ-012 SHALL have port vld_o, output, 1 bit: single-cycle pulse qualifying data_o.
REQ-013 SHALL have port busy, output, 1 bit: high while the block cannot accept a sample.
REQ-014 SHALL have port ovr, output, 1 bit: sticky flag, set when a vld_i pulse is dropped.

Function
REQ-015 SHALL hold a DEPTH x DATA_W single-port or simple-dual-port RAM with a registered read, inferable as block RAM.
REQ-016 SHALL have FSM states CLEAR, IDLE, RD and WR.
REQ-017 SHALL behave as follows in CLEAR:
- writes 0 to address clr_cnt each cycle, with clr_cnt running 0..DEPTH-1;
- after the write to DEPTH-1, moves to IDLE and sets wr_ptr=0;
- CLEAR lasts exactly DEPTH cycles.
REQ-018 SHALL, in IDLE with vld_i=1:
- capture x=data_i;
- present read address (wr_ptr - delay) mod DEPTH;
- move to RD.
REQ-019 SHALL, in RD, register the RAM output q and move to WR.
REQ-020 SHALL, in WR:
- compute y;
- write mem[wr_ptr]=y;
- register data_o=y;
- increment wr_ptr mod DEPTH;
- move to IDLE.
REQ-021 SHALL assert vld_o for exactly one cycle, the cycle after WR, giving a latency of 3 clock edges from the edge that samples vld_i.
REQ-022 SHALL compute y, when en=1 and gain!=0, as sat(x + (q >>> gain)):
- arithmetic shift, rounding toward negative infinity;
- sum formed at DATA_W+1 bits;
- saturated to [-2^(DATA_W-1), 2^(DATA_W-1)-1].
REQ-023 SHALL set y=x when en=0 or gain=0; the buffer is still written with y, so re-enabling starts from a clean history.
REQ-024 SHALL, when delay=0, read the location about to be overwritten (read precedes write), yielding a DEPTH-sample echo.
REQ-025 SHALL sample en, delay and gain in the IDLE capture cycle and hold them for that sample.
REQ-026 SHALL drive busy=1 in CLEAR, RD and WR, and busy=0 in IDLE.
REQ-027 SHALL ignore vld_i=1 in RD or WR and set ovr=1; ovr clears only on reset.
REQ-028 SHALL ignore vld_i in CLEAR without setting ovr.
REQ-029 SHALL keep data_o at its last value between vld_o pulses.

Reset
REQ-030 SHALL, on rst_n=0, immediately and asynchronously force:
- state=CLEAR, clr_cnt=0, wr_ptr=0;
- data_o=0, vld_o=0, ovr=0, busy=1.
REQ-031 SHALL abandon any sample in RD or WR when reset is asserted mid-operation, with no vld_o; RAM contents are not required to be reset, since CLEAR re-zeroes them.
REQ-032 SHALL begin CLEAR on the first rising clk edge after rst_n deasserts.

Verification (DEPTH=16, DATA_W=24)
REQ-033 SHALL cover reset release: busy=1 for exactly 16 cycles, then 0; data_o=0, vld_o=0, ovr=0 throughout.
REQ-034 SHALL cover impulse with en=1, delay=4, gain=1, input 0x100000 then zeros every 4 cycles:
- outputs 0x100000, 0, 0, 0, 0x080000, 0, 0, 0, 0x040000;
- each vld_o occurs 3 edges after its vld_i.
REQ-035 SHALL cover saturation with delay=1, gain=1: input 0x7FFFF0 then 0x7FFFF0 gives outputs 0x7FFFF0, 0x7FFFFF; inputs 0x800000, 0x800000 give 0x800000, 0x800000.
REQ-036 SHALL cover bypass then re-enable:
- en=0 with inputs 0x123456 and 0xFEDCBA gives identical outputs;
- then en=1, delay=2, gain=2 with input 0 gives output 0x048D15 (0x123456 >>> 2).
REQ-037 SHALL cover overrun: vld_i pulses 1 cycle apart give one vld_o and ovr=1; ovr stays 1 until rst_n=0.
REQ-038 SHALL cover mid-operation reset: rst_n pulsed low during RD gives vld_o never asserted for that sample, data_o=0 and busy=1 immediately, then a fresh 16-cycle CLEAR.

Source files
------------

// File: rtl/eff_echo.sv
// eff_echo: feedback echo; each sample is mixed with an attenuated copy of the
// output from `delay` samples earlier, using a block-RAM delay line.
// Ports: clk, rst_n (async low), en (1=echo), delay (0=DEPTH), gain (>>> amount,
//   0=mute), data_i/vld_i (input sample + pulse), data_o/vld_o (output + pulse),
//   busy (cannot accept a sample), ovr (sticky: a sample was dropped).
module eff_echo #(
  parameter int DATA_W = 24,
  parameter int DEPTH = 4096,
  localparam int ADDR_W = $clog2(DEPTH)
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic [ADDR_W-1:0]        delay,
  input  logic [2:0]               gain,
  input  logic signed [DATA_W-1:0] data_i,
  input  logic                     vld_i,
  output logic signed [DATA_W-1:0] data_o,
  output logic                     vld_o,
  output logic                     busy,
  output logic                     ovr
);

  typedef enum logic [1:0] {
    CLEAR,
    IDLE,
    RD,
    WR
  } state_t;

  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(DEPTH - 1);
  localparam logic signed [DATA_W-1:0] SMAX = {1'b0, {(DATA_W-1){1'b1}}};
  localparam logic signed [DATA_W-1:0] SMIN = {1'b1, {(DATA_W-1){1'b0}}};

  state_t state_q, state_d;

  logic [ADDR_W-1:0]        clr_cnt_q;
  logic [ADDR_W-1:0]        wr_ptr_q;
  logic [ADDR_W-1:0]        rd_addr;
  logic signed [DATA_W-1:0] x_q;
  logic signed [DATA_W-1:0] q_q;
  logic signed [DATA_W-1:0] rd_q;
  logic signed [DATA_W-1:0] data_q;
  logic signed [DATA_W-1:0] shf;
  logic signed [DATA_W-1:0] y;
  logic signed [DATA_W:0]   sum;
  logic                     en_q;
  logic [2:0]               gain_q;
  logic                     vld_q;
  logic                     ovr_q;

  logic [DATA_W-1:0] mem [DEPTH];
  logic              we;
  logic              re;
  logic [ADDR_W-1:0] waddr;
  logic [DATA_W-1:0] wdata;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      CLEAR:   if (clr_cnt_q == LAST) state_d = IDLE;
      IDLE:    if (vld_i) state_d = RD;
      RD:      state_d = WR;
      WR:      state_d = IDLE;
      default: state_d = CLEAR;
    endcase
  end

  // Mix in DATA_W+1 bits so the saturation test is a simple sign check.
  always_comb begin
    shf = q_q >>> gain_q;
    sum = {x_q[DATA_W-1], x_q} + {shf[DATA_W-1], shf};
    y   = x_q;
    if (en_q && (gain_q != 3'd0)) begin
      if (sum[DATA_W] != sum[DATA_W-1]) begin
        y = sum[DATA_W] ? SMIN : SMAX;
      end else begin
        y = sum[DATA_W-1:0];
      end
    end
  end

  // Reads happen only in IDLE and writes only in CLEAR/WR, so one port
  // suffices; delay=0 reads the slot WR overwrites two cycles later.
  always_comb begin
    rd_addr = wr_ptr_q - delay;
    re      = (state_q == IDLE) && vld_i;
    we      = 1'b0;
    waddr   = wr_ptr_q;
    wdata   = '0;
    unique case (state_q)
      CLEAR: begin
        we    = 1'b1;
        waddr = clr_cnt_q;
      end
      WR: begin
        we    = 1'b1;
        wdata = y;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rd_q <= mem[rd_addr];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= CLEAR;
      clr_cnt_q <= '0;
      wr_ptr_q  <= '0;
      x_q       <= '0;
      q_q       <= '0;
      en_q      <= 1'b0;
      gain_q    <= 3'd0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      ovr_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      vld_q   <= 1'b0;
      unique case (state_q)
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + ADDR_W'(1);
          if (clr_cnt_q == LAST) wr_ptr_q <= '0;
        end
        IDLE: begin
          if (vld_i) begin
            x_q    <= data_i;
            en_q   <= en;
            gain_q <= gain;
          end
        end
        RD: begin
          q_q <= rd_q;
          if (vld_i) ovr_q <= 1'b1;
        end
        WR: begin
          data_q   <= y;
          vld_q    <= 1'b1;
          wr_ptr_q <= wr_ptr_q + ADDR_W'(1);
          if (vld_i) ovr_q <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign data_o = data_q;
  assign vld_o  = vld_q;
  assign ovr    = ovr_q;
  assign busy   = (state_q != IDLE);

endmodule

// File: tb/tb_eff_echo.sv
// tb_eff_echo: directed checks of eff_echo at DEPTH=16, DATA_W=24.
// Covers reset/clear, impulse echo, saturation, bypass, overrun, mid-op reset.
module tb_eff_echo;

  localparam int DW = 24;
  localparam int DP = 16;
  localparam int AW = 4;

  logic                 clk;
  logic                 rst_n;
  logic                 en;
  logic [AW-1:0]        delay;
  logic [2:0]           gain;
  logic signed [DW-1:0] data_i;
  logic                 vld_i;
  logic signed [DW-1:0] data_o;
  logic                 vld_o;
  logic                 busy;
  logic                 ovr;

  int checks = 0;
  int errors = 0;

  eff_echo #(
    .DATA_W(DW),
    .DEPTH (DP)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (en),
    .delay (delay),
    .gain  (gain),
    .data_i(data_i),
    .vld_i (vld_i),
    .data_o(data_o),
    .vld_o (vld_o),
    .busy  (busy),
    .ovr   (ovr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  // Count edges until busy drops; outputs must stay quiet throughout.
  // poke holds vld_i high for the first edges of CLEAR.
  task automatic wait_clear(input bit poke);
    int  n;
    bit  bad;
    n   = 0;
    bad = 1'b0;
    if (poke) begin
      data_i = 24'h000055;
      vld_i  = 1'b1;
    end
    while (n < 40) begin
      @(posedge clk);
      #1;
      n++;
      if (n == 3) vld_i = 1'b0;
      if (vld_o || ovr || (data_o != 0)) bad = 1'b1;
      if (!busy) break;
    end
    chk("clear_len", n, 16);
    chk("clear_quiet", {31'd0, bad}, 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b0);
  endtask

  // One sample: capture edge is edge 1, vld_o must follow edge 3.
  task automatic sample(input string tag, input logic [DW-1:0] in,
                        input logic [DW-1:0] exp);
    int n;
    @(negedge clk);
    data_i = in;
    vld_i  = 1'b1;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    n     = 1;
    while (!vld_o && n < 10) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_lat"}, n, 3);
    chk(tag, {8'd0, data_o}, {8'd0, exp});
    @(negedge clk);
  endtask

  logic [DW-1:0] imp_in [9];
  logic [DW-1:0] imp_ex [9];

  initial begin
    int nv;
    rst_n  = 1'b0;
    en     = 1'b0;
    delay  = '0;
    gain   = 3'd0;
    data_i = '0;
    vld_i  = 1'b0;

    #2;
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_data", {8'd0, data_o}, 32'd0);
    chk("rst_vld", {31'd0, vld_o}, 32'd0);
    chk("rst_ovr", {31'd0, ovr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b1);
    chk("clear_no_ovr", {31'd0, ovr}, 32'd0);

    // impulse
    en    = 1'b1;
    delay = 4'd4;
    gain  = 3'd1;
    foreach (imp_in[i]) begin
      imp_in[i] = '0;
      imp_ex[i] = '0;
    end
    imp_in[0] = 24'h100000;
    imp_ex[0] = 24'h100000;
    imp_ex[4] = 24'h080000;
    imp_ex[8] = 24'h040000;
    for (int i = 0; i < 9; i++) begin
      sample($sformatf("imp%0d", i), imp_in[i], imp_ex[i]);
      @(negedge clk);
    end
    @(posedge clk);
    #1;
    chk("vld_one_cycle", {31'd0, vld_o}, 32'd0);

    // saturation
    do_reset();
    delay = 4'd1;
    gain  = 3'd1;
    sample("sat_p0", 24'h7FFFF0, 24'h7FFFF0);
    sample("sat_p1", 24'h7FFFF0, 24'h7FFFFF);
    do_reset();
    sample("sat_n0", 24'h800000, 24'h800000);
    sample("sat_n1", 24'h800000, 24'h800000);

    // bypass, then re-enable
    do_reset();
    en = 1'b0;
    sample("byp0", 24'h123456, 24'h123456);
    sample("byp1", 24'hFEDCBA, 24'hFEDCBA);
    repeat (5) @(negedge clk);
    chk("hold", {8'd0, data_o}, 32'h00FEDCBA);
    en    = 1'b1;
    delay = 4'd2;
    gain  = 3'd2;
    sample("reen", 24'h000000, 24'h048D15);

    // overrun: two consecutive vld_i cycles
    do_reset();
    delay = 4'd1;
    gain  = 3'd1;
    @(negedge clk);
    data_i = 24'h000100;
    vld_i  = 1'b1;
    @(negedge clk);
    data_i = 24'h000200;
    @(negedge clk);
    vld_i = 1'b0;
    nv    = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (vld_o) nv++;
    end
    chk("ovr_nvld", nv, 1);
    chk("ovr_data", {8'd0, data_o}, 32'h00000100);
    chk("ovr_set", {31'd0, ovr}, 32'd1);
    sample("ovr_after", 24'h000010, 24'h000090);
    chk("ovr_sticky", {31'd0, ovr}, 32'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("ovr_rst", {31'd0, ovr}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b0);

    // mid-operation reset during RD
    sample("pre_mid", 24'h000123, 24'h000123);
    @(negedge clk);
    data_i = 24'h000456;
    vld_i  = 1'b1;
    @(posedge clk);
    #1;
    vld_i = 1'b0;
    chk("mid_in_rd", {31'd0, busy}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_data", {8'd0, data_o}, 32'd0);
    chk("mid_busy", {31'd0, busy}, 32'd1);
    chk("mid_vld", {31'd0, vld_o}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    wait_clear(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
